sa_result_collector: RTL and testbench
======================================

Name: sa_result_collector

Overview:
- Receive end of the systolic array's result shift-out path.
- When the array controller asserts the PE-output shift enable, this block captures one row of accumulated PE results per valid beat into an N x N result buffer.
- After capture it streams the matrix to the host side row by row over a valid/ready handshake.
- It signals busy back to the controller so that no new shift-out starts while the buffer is still occupied.

Parameters:
- N, 4, array dimension (rows = columns); beats per matrix = N.
- DW, 16, signed PE accumulator width per lane.
- OW, 16, signed output width per lane; OW <= DW.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  PE output shift enable from the controller; one row per asserted cycle.
- res_data  in  N*DW  one row of PE results; lane j at bits [j*DW +: DW].
- busy  out  1  buffer not free; controller must hold res_valid low while busy=1.
- m_valid  out  1  output row valid.
- m_ready  in  1  host accepts row.
- m_data  out  N*OW  output row; lane j at [j*OW +: OW].
- m_row  out  log2(N)  index of the row on m_data.
- m_last  out  1  high with row N-1.
- ovf_err  out  1  sticky: res_valid seen while busy.
- done  out  1  one-cycle pulse when the last row handshakes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, beat counter=0, row pointer=0.
  - busy=0, m_valid=0, m_last=0, m_row=0, m_data=0, ovf_err=0, done=0.
  - Buffer contents are don't-care.
  - Reset mid-COLLECT or mid-DRAIN discards the partial matrix.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - res_valid=1 writes res_data into buffer row N-1, sets beat counter to 1, goes to COLLECT.
  - The first beat is the bottom array row; rows arrive bottom-first.
- COLLECT:
  - Each res_valid=1 cycle writes buffer row (N-1-beat) and increments the counter.
  - Gaps (res_valid=0) are allowed; the counter holds.
  - On the N-th beat, go to DRAIN on the next edge.
- busy:
  - registered; goes to 1 the cycle after the N-th beat is captured.
  - Stays 1 through all of DRAIN.
  - Returns to 0 the cycle after the last row handshakes.
  - busy=0 during COLLECT so that a multi-beat burst is uninterrupted.
- DRAIN:
  - m_valid=1 and m_data = buffer row pointer (top row 0 first); m_row = row pointer.
  - m_valid, m_data and m_row are registered and stable while m_valid=1 and m_ready=0.
  - On m_valid & m_ready: the row pointer increments and the next row appears the following cycle, giving full throughput with m_ready tied high.
  - On handshake of row N-1 (m_last=1): done pulses in the same cycle, then the next edge gives state=IDLE, m_valid=0, pointer=0.
- Latency: last captured beat to first m_valid = 1 cycle. N beats plus N accepted rows means 2N cycles minimum per matrix.
- res_valid while busy=1: the data is dropped, ovf_err sets and stays 1 until rst, and the buffer is not corrupted.
- Simultaneous final handshake and res_valid:
  - busy is still 1 in that cycle, so the beat is dropped and ovf_err sets.
  - The controller must observe busy=0 first.
- Width rule without saturation: each lane outputs its low OW bits (truncation; identity when OW=DW).

Optional Feature:
- Macro: SA_RESULT_SAT_EN.
- Defined: each lane saturates signed DW to OW.
  - Value > 2^(OW-1)-1 gives 2^(OW-1)-1.
  - Value < -2^(OW-1) gives -2^(OW-1).
  - A sticky sat_flag output (1 bit, reset 0) sets on any clipped lane of an accepted row.
- Undefined: truncation only; the sat_flag port does not exist.

Decomposition:
- Shared package sa_pkg:
  - constants SA_N, SA_DW, SA_OW.
  - state encoding constants SA_RC_IDLE=2'd0, SA_RC_COLLECT=2'd1, SA_RC_DRAIN=2'd2.
- One natural sub-module: sa_lane_sat (per-lane DW to OW saturate/truncate), instantiated N times on the buffer read path.

Test Plan:
- Reset, then 4 contiguous beats with row k lanes = 16*k+j, then m_ready=1:
  - m_valid rises 1 cycle after beat 4.
  - Rows are emitted in order 0..3, matching bottom-first reversal.
  - m_last is high on row 3, done pulses once, busy returns to 0.
- Beats with gaps (valid pattern 1,0,0,1,1,0,1): exactly 4 rows are captured; m_valid rises 1 cycle after the 4th valid.
- Backpressure m_ready=0 for 5 cycles on row 1: m_data and m_row stay constant; rows 2 and 3 follow with no loss or duplication.
- res_valid pulsed during DRAIN with data 0xDEAD in all lanes: ovf_err=1 stays sticky, and the drained rows are unchanged.
- rst asserted mid-COLLECT after 2 beats, then 4 new beats: only the new matrix is output; all outputs are 0 on the reset cycle.
- SA_RESULT_SAT_EN, DW=16, OW=8, lanes 0x0100, 0xFF00, 0x0005, 0xFFFB: output 0x7F, 0x80, 0x05, 0xFB; sat_flag=1.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared constants for the systolic-array result path: array geometry and the
// collector's state encoding.
package sa_pkg;
  localparam int SA_N  = 4;
  localparam int SA_DW = 16;
  localparam int SA_OW = 16;

  localparam logic [1:0] SA_RC_IDLE    = 2'd0;
  localparam logic [1:0] SA_RC_COLLECT = 2'd1;
  localparam logic [1:0] SA_RC_DRAIN   = 2'd2;
endpackage

// File: rtl/sa_lane_sat.sv
// One lane of the result read path: signed DW -> OW, truncating by default or
// saturating (with a clip indication) when SA_RESULT_SAT_EN is defined.
module sa_lane_sat
  import sa_pkg::*;
#(
  parameter int DW = SA_DW,
  parameter int OW = SA_OW
) (
  input  logic [DW-1:0] lane_i,
`ifdef SA_RESULT_SAT_EN
  output logic          clip_o,
`endif
  output logic [OW-1:0] lane_o
);

`ifdef SA_RESULT_SAT_EN
  logic fits;

  // Value is representable when every bit from the OW sign position upward agrees.
  assign fits   = (&lane_i[DW-1:OW-1]) | ~(|lane_i[DW-1:OW-1]);
  assign clip_o = ~fits;

  always_comb begin
    lane_o = lane_i[OW-1:0];
    if (!fits) begin
      lane_o = lane_i[DW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end
`else
  assign lane_o = lane_i[OW-1:0];
`endif

endmodule

// File: rtl/sa_result_collector.sv
// Captures N bottom-first result rows, drains them top-first over valid/ready; last beat -> m_valid in 1 cycle.
// Rows hold while m_ready=0; busy blocks new shift-outs. SA_RESULT_SAT_EN adds lane saturation and sat_flag.
module sa_result_collector
  import sa_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW,
  parameter int OW = SA_OW,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            res_valid,
  input  logic [N*DW-1:0] res_data,
  output logic            busy,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N*OW-1:0] m_data,
  output logic [RW-1:0]   m_row,
  output logic            m_last,
  output logic            ovf_err,
`ifdef SA_RESULT_SAT_EN
  output logic            sat_flag,
`endif
  output logic            done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [RW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic            m_valid_q, m_valid_d;
  logic [N*OW-1:0] m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic            ovf_q, ovf_d;
  logic [N*DW-1:0] buf_q [N];

  logic            capture, final_beat, hs, load;
  logic [RW-1:0]   wr_idx, rd_idx;
  logic [N*DW-1:0] rd_row;
  logic [N*OW-1:0] rd_conv;
`ifdef SA_RESULT_SAT_EN
  logic [N-1:0]    rd_clip;
`endif

  assign capture    = res_valid & ~busy_q;
  assign final_beat = capture & (beat_q == CW'(N - 1));
  assign hs         = m_valid_q & m_ready;
  assign load       = final_beat | (hs & ~m_last_q);
  assign wr_idx     = LAST_ROW - beat_q[RW-1:0];
  assign rd_idx     = ptr_q + RW'(1);

  // The final beat lands in row 0, so it bypasses the buffer straight to the output register.
  assign rd_row = final_beat ? res_data : buf_q[rd_idx];

  for (genvar j = 0; j < N; j++) begin : g_lane
    sa_lane_sat #(.DW(DW), .OW(OW)) u_sat (
      .lane_i (rd_row[j*DW +: DW]),
`ifdef SA_RESULT_SAT_EN
      .clip_o (rd_clip[j]),
`endif
      .lane_o (rd_conv[j*OW +: OW])
    );
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    ovf_d     = ovf_q | (res_valid & busy_q);
    case (state_q)
      SA_RC_IDLE, SA_RC_COLLECT: begin
        if (capture) begin
          state_d = SA_RC_COLLECT;
          beat_d  = beat_q + 1'b1;
          if (final_beat) begin
            state_d   = SA_RC_DRAIN;
            beat_d    = '0;
            ptr_d     = '0;
            busy_d    = 1'b1;
            m_valid_d = 1'b1;
            m_data_d  = rd_conv;
            m_last_d  = (N == 1);
          end
        end
      end
      SA_RC_DRAIN: begin
        if (hs) begin
          if (m_last_q) begin
            state_d   = SA_RC_IDLE;
            ptr_d     = '0;
            busy_d    = 1'b0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end else begin
            ptr_d    = rd_idx;
            m_data_d = rd_conv;
            m_last_d = (rd_idx == LAST_ROW);
          end
        end
      end
      default: state_d = SA_RC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SA_RC_IDLE;
      beat_q    <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q[wr_idx] <= res_data;
    end
  end

`ifdef SA_RESULT_SAT_EN
  logic [N-1:0] m_clip_q;
  logic         sat_q;

  // Clip bits travel with the registered row so the flag reflects accepted rows only.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_clip_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      if (load) begin
        m_clip_q <= rd_clip;
      end
      if (hs && (|m_clip_q)) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign sat_flag = sat_q;
`endif

  assign busy    = busy_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_row   = ptr_q;
  assign m_last  = m_last_q;
  assign ovf_err = ovf_q;
  assign done    = hs & m_last_q;

endmodule

// File: tb/tb_sa_result_collector.sv
// Bench for sa_result_collector: directed and random matrices against a model
// where output row r is the (N-1-r)-th beat received, lane-converted.
module tb_sa_result_collector;
  localparam int N  = 4;
  localparam int DW = 16;
`ifdef SA_RESULT_SAT_EN
  localparam int OW = 8;
`else
  localparam int OW = 16;
`endif
  localparam int RW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            res_valid;
  logic [N*DW-1:0] res_data;
  logic            busy;
  logic            m_valid;
  logic            m_ready;
  logic [N*OW-1:0] m_data;
  logic [RW-1:0]   m_row;
  logic            m_last;
  logic            ovf_err;
  logic            done;
`ifdef SA_RESULT_SAT_EN
  logic            sat_flag;
`endif

  sa_result_collector #(.N(N), .DW(DW), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .busy      (busy),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_last    (m_last),
    .ovf_err   (ovf_err),
`ifdef SA_RESULT_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [N*DW-1:0] mat [N];
  int gaps [N];

  function automatic logic [N*OW-1:0] conv_row(input logic [N*DW-1:0] row);
    logic [N*OW-1:0] o;
    logic signed [DW-1:0] v;
    longint x, maxv, minv;
    o = '0;
    maxv = (longint'(1) <<< (OW - 1)) - 1;
    minv = -(longint'(1) <<< (OW - 1));
    for (int j = 0; j < N; j++) begin
      v = row[j*DW +: DW];
      x = longint'(v);
`ifdef SA_RESULT_SAT_EN
      if (x > maxv) x = maxv;
      else if (x < minv) x = minv;
`endif
      o[j*OW +: OW] = x[OW-1:0];
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_mat();
    for (int k = 0; k < N; k++) mat[k] = {$urandom, $urandom};
  endtask

  // Sends mat[0..N-1] as beats with gaps[k] idle cycles before beat k.
  task automatic collect();
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        chk("busy_gap", busy, 0);
        chk("mvalid_gap", m_valid, 0);
        tick();
      end
      chk("busy_collect", busy, 0);
      res_valid = 1'b1;
      res_data  = mat[k];
      tick();
      res_valid = 1'b0;
      res_data  = {$urandom, $urandom};
      if (k < N - 1) chk("mvalid_early", m_valid, 0);
    end
    chk("mvalid_latency", m_valid, 1);
    chk("busy_after_fill", busy, 1);
    chk("mrow_first", m_row, 0);
  endtask

  // stall_row < -1 selects random stalls; inj_row injects a res_valid pulse.
  task automatic drain(input int stall_row, input int stall_len, input int inj_row, input bit inj_on_hs);
    int stall;
    for (int r = 0; r < N; r++) begin
      stall = (r == stall_row) ? stall_len : 0;
      if (stall_row < -1) stall = $urandom_range(0, 2);
      for (int c = 0; c <= stall; c++) begin
        chk("mvalid_drain", m_valid, 1);
        chk("mrow", m_row, r);
        chk("mdata", m_data, conv_row(mat[N-1-r]));
        chk("mlast", m_last, (r == N - 1));
        chk("busy_drain", busy, 1);
        m_ready = (c == stall);
        if (r == inj_row && (inj_on_hs ? (c == stall) : (c == 0))) begin
          res_valid = 1'b1;
          res_data  = {N{16'hDEAD}};
        end
        #1;
        chk("done", done, (c == stall) && (r == N - 1));
        tick();
        res_valid = 1'b0;
        m_ready   = 1'b0;
      end
    end
    chk("mvalid_end", m_valid, 0);
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
    chk("mrow_end", m_row, 0);
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; m_ready = 1'b0; res_data = '0;
    for (int k = 0; k < N; k++) gaps[k] = 0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_mrow", m_row, 0);
    chk("rst_mlast", m_last, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

`ifdef SA_RESULT_SAT_EN
    chk("rst_sat", sat_flag, 0);
    for (int k = 0; k < N; k++) mat[k] = {16'hFFFB, 16'h0005, 16'hFF00, 16'h0100};
    collect();
    chk("sat_lanes", m_data, 32'hFB05807F);
    chk("sat_before_accept", sat_flag, 0);
    drain(-1, 0, -1, 1'b0);
    chk("sat_sticky", sat_flag, 1);
`endif

    // Contiguous ramp matrix, full throughput.
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) mat[k][j*DW +: DW] = DW'(16 * k + j);
    collect();
    drain(-1, 0, -1, 1'b0);
    chk("ovf_clean", ovf_err, 0);

    // Valid pattern 1,0,0,1,1,0,1.
    rand_mat();
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 0; gaps[3] = 1;
    collect();
    drain(-1, 0, -1, 1'b0);
    for (int k = 0; k < N; k++) gaps[k] = 0;

    // Five-cycle backpressure on row 1.
    rand_mat();
    collect();
    drain(1, 5, -1, 1'b0);
    chk("ovf_still_clean", ovf_err, 0);

    // Beat coinciding with the final handshake is dropped.
    rand_mat();
    collect();
    drain(-1, 0, N - 1, 1'b1);
    chk("ovf_final_hs", ovf_err, 1);
    tick();
    chk("ovf_sticky_idle", ovf_err, 1);

    // Reset mid-collect, then a 0xDEAD pulse in the middle of a stalled drain.
    for (int k = 0; k < 2; k++) begin
      res_valid = 1'b1;
      res_data  = {$urandom, $urandom};
      tick();
    end
    res_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst2_busy", busy, 0);
    chk("rst2_mvalid", m_valid, 0);
    chk("rst2_mdata", m_data, 0);
    chk("rst2_mrow", m_row, 0);
    chk("rst2_mlast", m_last, 0);
    chk("rst2_ovf", ovf_err, 0);
    chk("rst2_done", done, 0);
    rst = 1'b0;
    rand_mat();
    collect();
    drain(1, 2, 1, 1'b0);
    chk("ovf_dead", ovf_err, 1);

    // Random matrices with random gaps and stalls.
    for (int t = 0; t < 6; t++) begin
      rand_mat();
      for (int k = 0; k < N; k++) gaps[k] = $urandom_range(0, 2);
      collect();
      drain(-2, 0, -1, 1'b0);
    end
    chk("ovf_final", ovf_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
